core_dmem_arbiter: RTL and testbench
====================================

Name: core_dmem_arbiter

Overview:
- Shares the single data-memory port between two requesters: port 0 is the core LSU, which feeds the writeback stage's load-data path; port 1 is an auxiliary master (debug/DMA).
- Arbitrates the request channel, tracks outstanding transactions in an in-order ID FIFO, and steers each response (rdata/err) back to the requester that issued it.
- Sits between the execute/writeback LSU logic and the memory bus.

Parameters:
- ADDR_W, 64, memory address width.
- DATA_W, 64, memory data width.
- STRB_W, 8, write strobe width (DATA_W/8).
- OUTSTANDING, 2, maximum in-flight transactions (ID FIFO depth, 1..4).

Ports:
- g_clk  in  1  clock.
- g_reset  in  1  reset, synchronous, active-high.
- r0_req  in  1  LSU request valid.
- r0_gnt  out  1  LSU request accepted.
- r0_addr / r0_wen / r0_strb / r0_wdata  in  ADDR_W / 1 / STRB_W / DATA_W  LSU request payload.
- r0_rsp  out  1  LSU response valid.
- r0_err  out  1  LSU response error.
- r0_rdata  out  DATA_W  LSU read data.
- r1_*  same set as r0_*  auxiliary requester.
- dmem_req  out  1  memory request valid.
- dmem_gnt  in  1  memory request accepted.
- dmem_addr / dmem_wen / dmem_strb / dmem_wdata  out  as above  selected payload.
- dmem_rsp  in  1  memory response valid (in order, at least 1 cycle after gnt, no backpressure).
- dmem_err  in  1  memory response error.
- dmem_rdata  in  DATA_W  memory read data.
- arb_err  out  1  sticky: a response arrived with no outstanding transaction.

Behaviour:
- One clock; reset is synchronous and active-high (g_clk, g_reset).
- Reset values: dmem_req=0, r0_gnt=r1_gnt=0, r0_rsp=r1_rsp=0, arb_err=0, FIFO empty, count=0, lock=0, last_grant=1 (so r0 wins the first tie).
- Request handshake: a transfer occurs on dmem_req && dmem_gnt. A requester holds its req high with a stable payload until it sees gnt.
- Grant path: rN_gnt = dmem_gnt && selected==N && issue_ok. This is combinational, 0-cycle.
- issue_ok = (count < OUTSTANDING). There is no full-bypass: when full, a response popping in the same cycle does not allow an issue that cycle.
- dmem_req = issue_ok && (r0_req || r1_req). The payload is muxed from the selected requester and is all-zero when none is selected.
- Arbitration FSM, states IDLE and LOCKED:
  - IDLE: if both request, select the port != last_grant (round-robin); otherwise select the single requester.
  - If dmem_req && !dmem_gnt, go to LOCKED with the selection held. The selection must not change while the memory sees an unaccepted request, even if the other port asserts or has higher round-robin priority.
  - LOCKED -> IDLE on the transfer. Mid-request, the memory side must not see a requester drop its req (protocol violation, unchecked).
  - On transfer: push the selected ID, update last_grant.
- Response path: on dmem_rsp, pop the FIFO head and drive rHEAD_rsp=1, with rdata/err passed through combinationally. The other port's rsp stays 0, and its rdata/err are zero.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Response when the FIFO is empty: drop it (no rN_rsp), set arb_err=1 until reset. The count must not underflow.
- Pointers wrap modulo OUTSTANDING; use a log2 pointer plus a separate count so non-power-of-2 depths work.
- Reset mid-operation: the FIFO, lock and count clear in the same cycle. The memory shares g_reset, so no responses to pre-reset requests are expected.

Decomposition:
- Shared package: DMEM_ID_CORE=1'b0, DMEM_ID_AUX=1'b1, and the arbiter state typedef (ARB_IDLE, ARB_LOCKED).
- One natural sub-module: core_dmem_id_fifo (depth OUTSTANDING, width 1, push/pop/full/empty/count, synchronous active-high reset).

Test Plan:
- Single LSU load: r0_req with addr=0x1000, gnt same cycle, dmem_rsp 2 cycles later with rdata=0xDEADBEEF -> r0_rsp=1 with that data, r1_rsp=0, arb_err=0.
- Both requesting continuously, gnt always 1 -> grants alternate r0, r1, r0, r1 starting with r0 after reset; responses route in matching order.
- r0 requesting and stalled (gnt=0 for 3 cycles), r1 asserts during the stall -> dmem_addr stays r0's for all 4 cycles, r0 is granted, then r1.
- OUTSTANDING=2, two grants with no responses -> dmem_req=0 on the third cycle despite r0_req=1. On the cycle dmem_rsp arrives, dmem_req stays 0; it asserts the following cycle.
- dmem_rsp with an empty FIFO -> no rN_rsp, arb_err=1 and it stays 1 until g_reset, then clears.
- g_reset asserted with 2 outstanding -> next cycle count=0, dmem_req follows new requests, and r0 wins the first tie.

Source files
------------

// File: rtl/core_dmem_arbiter_pkg.sv
// rtl/core_dmem_arbiter_pkg.sv - shared IDs and arbiter state for the data-memory arbiter
package core_dmem_arbiter_pkg;

  localparam logic DMEM_ID_CORE = 1'b0;
  localparam logic DMEM_ID_AUX  = 1'b1;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/core_dmem_arbiter_id_fifo.sv
// rtl/core_dmem_arbiter_id_fifo.sv - in-order requester-ID FIFO for outstanding memory transactions
module core_dmem_id_fifo #(
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_dmem_arbiter.sv
// rtl/core_dmem_arbiter.sv - shares the data-memory port between the LSU (port 0) and an aux master (port 1)
module core_dmem_arbiter
  import core_dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int STRB_W      = 8,
  parameter int OUTSTANDING = 2
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              r0_req,
  output logic              r0_gnt,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic              r0_wen,
  input  logic [STRB_W-1:0] r0_strb,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rsp,
  output logic              r0_err,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  output logic              r1_gnt,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic              r1_wen,
  input  logic [STRB_W-1:0] r1_strb,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rsp,
  output logic              r1_err,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wen,
  output logic [STRB_W-1:0] dmem_strb,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_rsp,
  input  logic              dmem_err,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              arb_err
);

  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  arb_state_t       state;
  logic             last_grant;
  logic             locked_sel;
  logic             sel;
  logic             any_req;
  logic             issue_ok;
  logic             xfer;
  logic             rsp_hit;
  logic             head_id;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // While locked the memory already sees a request; the selection must not move.
  always_comb begin
    sel = DMEM_ID_CORE;
    if (state == ARB_LOCKED) begin
      sel = locked_sel;
    end else if (r0_req && r1_req) begin
      sel = ~last_grant;
    end else if (r1_req) begin
      sel = DMEM_ID_AUX;
    end
  end

  assign any_req  = r0_req || r1_req;
  assign issue_ok = (fifo_count < CNT_W'(OUTSTANDING));
  assign dmem_req = issue_ok && any_req;
  assign xfer     = dmem_req && dmem_gnt;
  assign r0_gnt   = xfer && (sel == DMEM_ID_CORE);
  assign r1_gnt   = xfer && (sel == DMEM_ID_AUX);

  always_comb begin
    dmem_addr  = '0;
    dmem_wen   = 1'b0;
    dmem_strb  = '0;
    dmem_wdata = '0;
    if (any_req) begin
      if (sel == DMEM_ID_AUX) begin
        dmem_addr  = r1_addr;
        dmem_wen   = r1_wen;
        dmem_strb  = r1_strb;
        dmem_wdata = r1_wdata;
      end else begin
        dmem_addr  = r0_addr;
        dmem_wen   = r0_wen;
        dmem_strb  = r0_strb;
        dmem_wdata = r0_wdata;
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state      <= ARB_IDLE;
      locked_sel <= DMEM_ID_CORE;
      last_grant <= DMEM_ID_AUX;
      arb_err    <= 1'b0;
    end else begin
      if (xfer) begin
        state      <= ARB_IDLE;
        last_grant <= sel;
      end else if (dmem_req) begin
        state      <= ARB_LOCKED;
        locked_sel <= sel;
      end
      if (dmem_rsp && fifo_empty) begin
        arb_err <= 1'b1;
      end
    end
  end

  core_dmem_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (g_clk),
    .reset (g_reset),
    .push  (xfer && !fifo_full),
    .pop   (rsp_hit),
    .din   (sel),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Responses with nothing outstanding are dropped here and flagged via arb_err.
  assign rsp_hit  = dmem_rsp && !fifo_empty;
  assign r0_rsp   = rsp_hit && (head_id == DMEM_ID_CORE);
  assign r1_rsp   = rsp_hit && (head_id == DMEM_ID_AUX);
  assign r0_rdata = r0_rsp ? dmem_rdata : '0;
  assign r0_err   = r0_rsp ? dmem_err : 1'b0;
  assign r1_rdata = r1_rsp ? dmem_rdata : '0;
  assign r1_err   = r1_rsp ? dmem_err : 1'b0;

endmodule

// File: tb/tb_core_dmem_arbiter.sv
// tb/tb_core_dmem_arbiter.sv - directed self-checking bench for core_dmem_arbiter
module tb_core_dmem_arbiter;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        r0_req, r0_gnt, r0_wen, r0_rsp, r0_err;
  logic [63:0] r0_addr, r0_wdata, r0_rdata;
  logic [7:0]  r0_strb;
  logic        r1_req, r1_gnt, r1_wen, r1_rsp, r1_err;
  logic [63:0] r1_addr, r1_wdata, r1_rdata;
  logic [7:0]  r1_strb;
  logic        dmem_req, dmem_gnt, dmem_wen, dmem_rsp, dmem_err, arb_err;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_strb;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  core_dmem_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STRB_W(8), .OUTSTANDING(2)
  ) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_addr(r0_addr), .r0_wen(r0_wen),
    .r0_strb(r0_strb), .r0_wdata(r0_wdata), .r0_rsp(r0_rsp), .r0_err(r0_err),
    .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_addr(r1_addr), .r1_wen(r1_wen),
    .r1_strb(r1_strb), .r1_wdata(r1_wdata), .r1_rsp(r1_rsp), .r1_err(r1_err),
    .r1_rdata(r1_rdata),
    .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
    .dmem_wen(dmem_wen), .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata),
    .dmem_rsp(dmem_rsp), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge g_clk);
    #1;
  endtask

  task automatic to_check();
    @(negedge g_clk);
  endtask

  task automatic rsp(input logic v, input logic [63:0] d, input logic e);
    dmem_rsp = v; dmem_rdata = d; dmem_err = e;
  endtask

  initial begin
    g_reset = 1'b1;
    r0_req = 0; r0_addr = 0; r0_wen = 0; r0_strb = 0; r0_wdata = 0;
    r1_req = 0; r1_addr = 0; r1_wen = 0; r1_strb = 0; r1_wdata = 0;
    dmem_gnt = 0; rsp(0, 0, 0);
    to_drive(); to_drive();
    g_reset = 1'b0; dmem_gnt = 1'b1;
    to_check();
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_r0_gnt", r0_gnt, 0);
    chk("rst_r1_gnt", r1_gnt, 0);
    chk("rst_r0_rsp", r0_rsp, 0);
    chk("rst_r1_rsp", r1_rsp, 0);
    chk("rst_arb_err", arb_err, 0);
    chk("rst_addr_zero", dmem_addr, 0);

    // single LSU load
    to_drive(); r0_req = 1; r0_addr = 64'h1000; dmem_gnt = 1;
    to_check();
    chk("ld_dmem_req", dmem_req, 1);
    chk("ld_addr", dmem_addr, 64'h1000);
    chk("ld_r0_gnt", r0_gnt, 1);
    chk("ld_r1_gnt", r1_gnt, 0);
    to_drive(); r0_req = 0; dmem_gnt = 0;
    to_drive(); rsp(1, 64'hDEADBEEF, 0);
    to_check();
    chk("ld_r0_rsp", r0_rsp, 1);
    chk("ld_r0_rdata", r0_rdata, 64'hDEADBEEF);
    chk("ld_r1_rsp", r1_rsp, 0);
    chk("ld_arb_err", arb_err, 0);
    to_drive(); rsp(0, 0, 0);

    // round robin after reset, responses routed in order
    g_reset = 1; to_drive(); g_reset = 0;
    r0_req = 1; r0_addr = 64'h100; r1_req = 1; r1_addr = 64'h200; dmem_gnt = 1;
    to_check();
    chk("rr1_r0_gnt", r0_gnt, 1);
    chk("rr1_r1_gnt", r1_gnt, 0);
    chk("rr1_addr", dmem_addr, 64'h100);
    to_drive(); rsp(1, 64'hA0, 0);
    to_check();
    chk("rr2_r1_gnt", r1_gnt, 1);
    chk("rr2_r0_gnt", r0_gnt, 0);
    chk("rr2_addr", dmem_addr, 64'h200);
    chk("rr2_r0_rsp", r0_rsp, 1);
    chk("rr2_r0_rdata", r0_rdata, 64'hA0);
    chk("rr2_r1_rsp", r1_rsp, 0);
    to_drive(); rsp(1, 64'hA1, 0);
    to_check();
    chk("rr3_r0_gnt", r0_gnt, 1);
    chk("rr3_r1_rsp", r1_rsp, 1);
    chk("rr3_r1_rdata", r1_rdata, 64'hA1);
    chk("rr3_r0_rdata", r0_rdata, 0);
    to_drive(); rsp(1, 64'hA2, 0);
    to_check();
    chk("rr4_r1_gnt", r1_gnt, 1);
    chk("rr4_r0_rsp", r0_rsp, 1);
    chk("rr4_r0_rdata", r0_rdata, 64'hA2);
    to_drive(); r0_req = 0; r1_req = 0; dmem_gnt = 0; rsp(1, 64'hA3, 0);
    to_check();
    chk("rr5_r1_rsp", r1_rsp, 1);
    chk("rr5_r1_rdata", r1_rdata, 64'hA3);
    chk("rr5_dmem_req", dmem_req, 0);
    chk("rr5_addr_zero", dmem_addr, 0);

    // stall lock: r0 stalled, r1 (now higher priority) arrives mid-stall
    to_drive(); rsp(0, 0, 0); r0_req = 1; r0_addr = 64'h2000; dmem_gnt = 1;
    to_check();
    chk("lk0_r0_gnt", r0_gnt, 1);
    to_drive(); r0_addr = 64'h3000; dmem_gnt = 0; rsp(1, 64'h55, 0);
    to_check();
    chk("lk1_addr", dmem_addr, 64'h3000);
    chk("lk1_r0_gnt", r0_gnt, 0);
    chk("lk1_r0_rsp", r0_rsp, 1);
    to_drive(); rsp(0, 0, 0);
    r1_req = 1; r1_addr = 64'h4000; r1_wen = 1; r1_strb = 8'h0F; r1_wdata = 64'h1234;
    to_check();
    chk("lk2_addr", dmem_addr, 64'h3000);
    chk("lk2_r1_gnt", r1_gnt, 0);
    to_drive();
    to_check();
    chk("lk3_addr", dmem_addr, 64'h3000);
    to_drive(); dmem_gnt = 1;
    to_check();
    chk("lk4_r0_gnt", r0_gnt, 1);
    chk("lk4_r1_gnt", r1_gnt, 0);
    chk("lk4_addr", dmem_addr, 64'h3000);
    to_drive(); r0_req = 0;
    to_check();
    chk("lk5_r1_gnt", r1_gnt, 1);
    chk("lk5_addr", dmem_addr, 64'h4000);
    chk("lk5_wen", dmem_wen, 1);
    chk("lk5_strb", dmem_strb, 8'h0F);
    chk("lk5_wdata", dmem_wdata, 64'h1234);
    to_drive(); r1_req = 0; r1_wen = 0; dmem_gnt = 0; rsp(1, 64'h30, 0);
    to_check();
    chk("lk6_r0_rsp", r0_rsp, 1);
    chk("lk6_r0_rdata", r0_rdata, 64'h30);
    to_drive(); rsp(1, 64'h40, 1);
    to_check();
    chk("lk7_r1_rsp", r1_rsp, 1);
    chk("lk7_r1_err", r1_err, 1);
    chk("lk7_r0_err", r0_err, 0);

    // outstanding limit, no full bypass
    to_drive(); rsp(0, 0, 0); r0_req = 1; r0_addr = 64'h5000; dmem_gnt = 1;
    to_check();
    chk("ful1_r0_gnt", r0_gnt, 1);
    to_drive();
    to_check();
    chk("ful2_r0_gnt", r0_gnt, 1);
    to_drive();
    to_check();
    chk("ful3_dmem_req", dmem_req, 0);
    chk("ful3_r0_gnt", r0_gnt, 0);
    to_drive(); rsp(1, 64'h51, 0);
    to_check();
    chk("ful4_dmem_req", dmem_req, 0);
    chk("ful4_r0_rsp", r0_rsp, 1);
    to_drive(); rsp(0, 0, 0);
    to_check();
    chk("ful5_dmem_req", dmem_req, 1);
    chk("ful5_r0_gnt", r0_gnt, 1);
    to_drive(); r0_req = 0; dmem_gnt = 0; rsp(1, 64'h52, 0);
    to_check();
    chk("ful6_r0_rdata", r0_rdata, 64'h52);
    to_drive(); rsp(1, 64'h53, 0);
    to_check();
    chk("ful7_r0_rdata", r0_rdata, 64'h53);
    to_drive(); rsp(0, 0, 0);
    to_check();
    chk("ful8_arb_err", arb_err, 0);

    // response with empty FIFO
    to_drive(); rsp(1, 64'h99, 0);
    to_check();
    chk("emp_r0_rsp", r0_rsp, 0);
    chk("emp_r1_rsp", r1_rsp, 0);
    to_drive(); rsp(0, 0, 0);
    to_check();
    chk("emp_arb_err_set", arb_err, 1);
    to_drive();
    to_check();
    chk("emp_arb_err_sticky", arb_err, 1);
    to_drive(); g_reset = 1;
    to_drive(); g_reset = 0;
    to_check();
    chk("emp_arb_err_clr", arb_err, 0);

    // reset with two outstanding
    to_drive(); r0_req = 1; r0_addr = 64'h6000; dmem_gnt = 1;
    to_drive();
    to_drive(); r0_req = 0; dmem_gnt = 0; g_reset = 1;
    to_drive(); g_reset = 0;
    r0_req = 1; r0_addr = 64'h7000; r1_req = 1; r1_addr = 64'h8000; dmem_gnt = 1;
    to_check();
    chk("rr_after_rst_req", dmem_req, 1);
    chk("rr_after_rst_r0_gnt", r0_gnt, 1);
    chk("rr_after_rst_r1_gnt", r1_gnt, 0);
    to_drive();
    to_check();
    chk("rr_after_rst_r1_next", r1_gnt, 1);
    to_drive(); r0_req = 0; r1_req = 0; dmem_gnt = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
